// File: rtl/noc_tx_pkt_arbiter_if.sv
// Requester-side and FIFO-side flit bus of the NoC TX packet arbiter.
// master: requesters + FIFO model; slave: the arbiter.
interface noc_tx_pkt_arbiter_if #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_head;
    logic [NUM_REQ-1:0]            req_tail;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH:0]           out_data;
    logic                          out_head;
    logic                          out_tail;
    logic                          out_full;

    modport master (
        output req_data, req_valid, req_head, req_tail, out_full,
        input  req_ready, out_data, out_head, out_tail
    );

    modport slave (
        input  req_data, req_valid, req_head, req_tail, out_full,
        output req_ready, out_data, out_head, out_tail
    );
endinterface

// File: rtl/noc_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter onto the NoC-bound flit FIFO.
// Ports: noc_clk/noc_rst, bus (slave), grant, busy, err_len, err_orphan.
module noc_tx_pkt_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_REQ    = 4,
    parameter int MAX_FLITS  = 16
) (
    input  logic                 noc_clk,
    input  logic                 noc_rst,
    noc_tx_pkt_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 err_len,
    output logic                 err_orphan
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_FLITS + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_len_q, err_len_d;
    logic               err_orph_q, err_orph_d;

    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    orphan;
    logic                  found;
    logic [PW-1:0]         sel;
    logic [PW:0]           sum;
    logic [PW-1:0]         idx;
    logic                  own_valid;
    logic                  own_head;
    logic                  own_tail;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  xfer;
    logic                  last;
    logic [PW-1:0]         rr_next;

    assign elig   = bus.req_valid & bus.req_head;
    assign orphan = bus.req_valid & ~bus.req_head;

    // Rotating priority search starting at rr_q.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            idx = sum[PW-1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Owner mux via the one-hot grant; all zero when nothing is granted.
    always_comb begin
        own_valid = |(bus.req_valid & grant_q);
        own_head  = |(bus.req_head & grant_q);
        own_tail  = |(bus.req_tail & grant_q);
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i])
                own_data = own_data
                         | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign xfer = (state_q == XFER) & own_valid & ~bus.out_full;
    assign last = (cnt_q == CW'(MAX_FLITS - 1));

    assign rr_next = (owner_q == PW'(NUM_REQ - 1)) ? '0
                   : owner_q + PW'(1);

    // IDLE drops body flits; XFER only ever acks the owner.
    assign bus.req_ready = (state_q == IDLE) ? orphan
                         : (grant_q & {NUM_REQ{xfer}});
    assign bus.out_data  = {xfer, own_data};
    assign bus.out_head  = own_head & xfer;
    assign bus.out_tail  = xfer & (own_tail | last);

    assign grant      = grant_q;
    assign busy       = (state_q == XFER);
    assign err_len    = err_len_q;
    assign err_orphan = err_orph_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        err_len_d  = 1'b0;
        err_orph_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                err_orph_d = |orphan;
                if (found) begin
                    state_d = XFER;
                    grant_d = NUM_REQ'(1) << sel;
                    owner_d = sel;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                    if (own_tail || last) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        rr_d      = rr_next;
                        err_len_d = ~own_tail;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            err_len_q  <= 1'b0;
            err_orph_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            err_len_q  <= err_len_d;
            err_orph_q <= err_orph_d;
        end
    end
endmodule
